matrix_axis_rx: RTL and testbench
=================================

Name: matrix_axis_rx

Overview:
- Receive-side companion to the matrix transpose core; the "reader" end of its output AXI-stream.
- The transpose core drives m_axis_tvalid without honouring backpressure. This block absorbs that stream into a small FIFO and re-frames it (SOF, end-of-row, TLAST).
- It presents a fully compliant AXI-stream master to downstream logic and reports drops, frame counts and overflow status.

Parameters:
- DATA_WIDTH, 32, element width; must match the transpose core.
- ROW, 64, source row count; it becomes the transposed row length, in elements per output line.
- CLO, 2400, source column count; it becomes the number of transposed lines per frame.
- FIFO_DEPTH, 16, entries in the elastic buffer; power of 2, at least 4.
- CNT_WIDTH, 16, width of the frame_cnt and drop_cnt status counters.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  element from the transpose core
- s_axis_tvalid  in  1  element valid
- s_axis_tready  out  1  buffer can accept
- m_axis_tdata  out  DATA_WIDTH  element to downstream
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last element of frame (ROW*CLO-th)
- m_axis_tuser  out  2  [0] start of frame, [1] last element of a line (every ROW-th)
- frame_done  out  1  one-cycle pulse on the TLAST output handshake
- frame_cnt  out  CNT_WIDTH  frames delivered; wraps
- drop_cnt  out  CNT_WIDTH  input beats dropped; saturates at all-ones
- ovf_err  out  1  sticky overflow flag
- err_clr  in  1  clears ovf_err and drop_cnt

Behaviour:
- Reset (rst_n low, async assert, sync deassert by system):
  - FIFO empty; all counters 0.
  - m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done and ovf_err are 0; m_axis_tdata is 0.
  - s_axis_tready is 1 from the first clock after release.
- s_axis_tready = !fifo_full. It is a registered-flag path only, with no combinational path from m_axis_tready.
- Input accept: s_axis_tvalid && s_axis_tready.
  - Push {tdata, sof, eol, eof} into the FIFO.
  - Tags come from input-side counters: elem_idx in 0..ROW-1 and line_idx in 0..CLO-1.
  - sof = (elem_idx==0 && line_idx==0); eol = (elem_idx==ROW-1); eof = eol && (line_idx==CLO-1).
- Input drop: s_axis_tvalid && !s_axis_tready.
  - The beat is discarded, ovf_err is set to 1, and drop_cnt increments, saturating.
  - elem_idx and line_idx still advance, so that later frame boundaries stay aligned with the transpose core's frame structure.
- Counter wrap: elem_idx wraps at ROW-1 and bumps line_idx; line_idx wraps at CLO-1 back to 0. There is no idle gap requirement between frames.
- Output is first-word-fall-through:
  - m_axis_tvalid = !fifo_empty.
  - tdata, tlast and tuser are driven from the FIFO head.
  - Latency: a beat accepted at edge N is visible on m_axis after edge N, so a handshake is possible at edge N+1.
- m_axis_tdata, tlast and tuser must be held stable while tvalid=1 && tready=0. m_axis_tvalid never deasserts without a handshake.
- Simultaneous push and pop: both happen and the occupancy is unchanged. When the FIFO is full and a pop occurs in the same cycle as s_axis_tvalid, the input beat is still dropped, because ready was 0 that cycle.
- frame_done:
  - Registered one-cycle pulse in the cycle after an m_axis handshake with tlast=1.
  - frame_cnt increments in the same cycle and wraps modulo 2^CNT_WIDTH.
- err_clr: clears ovf_err and drop_cnt next edge. If a drop occurs in the same cycle, the drop wins: ovf_err=1 and drop_cnt=1.
- Occupancy uses a pointer width of log2(FIFO_DEPTH)+1 for full/empty disambiguation.

Decomposition:
- Shared package matrix_pkg:
  - FRAME_LEN(ROW,CLO) function.
  - clog2-based width constants for elem_idx, line_idx and FIFO pointers.
  - typedef rx_beat_t as a packed struct {data, sof, eol, eof}.
- Sub-module axis_sync_fifo:
  - Parameters DEPTH and WIDTH.
  - FWFT; full and empty flags; push, pop, din, dout.
  - Also reusable on the transpose core's input side.

Test Plan:
- Single frame, no backpressure (ROW=4, CLO=3, data 1..12):
  - 12 output beats with the same values in order.
  - tuser[0] on beat 1 only; tuser[1] on beats 4, 8, 12; tlast on beat 12 only.
  - frame_done pulses once; frame_cnt=1.
- Backpressure (FIFO_DEPTH=16, ROW=4, CLO=5, m_axis_tready=0 for the 20-beat frame, then 1):
  - 16 beats stored; s_axis_tready low after the 16th.
  - drop_cnt=4, ovf_err=1; no tlast is emitted for this frame.
  - The next frame's first beat carries tuser[0]=1.
- Random m_axis_tready stall pattern (30% low) during 3 back-to-back frames:
  - Output data is held stable during every stall.
  - frame_cnt=3; tlast count equals 3.
- Simultaneous events:
  - err_clr asserted in the same cycle as a drop gives drop_cnt=1 and ovf_err=1.
  - err_clr alone gives 0/0.
- Reset mid-frame (rst_n low after beat 5 of 12, while holding 3 entries):
  - Outputs clear immediately (async).
  - After release, a new 12-beat frame is framed from beat 1 with tuser[0]=1 and frame_cnt=1.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, width helpers and beat tag type for the matrix transpose
// stream path.
package matrix_pkg;

    function automatic int FRAME_LEN(input int row, input int clo);
        return row * clo;
    endfunction

    // Index counter width; a one-entry range still needs a 1-bit counter.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The extra MSB separates full from empty when the address bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } rx_tag_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is always visible
// on dout_o while empty_o is low.
module axis_sync_fifo
    import matrix_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/matrix_axis_rx.sv
// Receive side of the transpose core: buffers its non-backpressured stream,
// re-frames it (SOF / end-of-line / TLAST) and reports drops and frame counts.
module matrix_axis_rx
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROW        = 64,
    parameter int CLO        = 2400,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            m_axis_tuser,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  ovf_err,
    input  logic                  err_clr
);
    localparam int EW = idx_w(ROW);
    localparam int LW = idx_w(CLO);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        rx_tag_t               tag;
    } rx_beat_t;

    localparam int BW = $bits(rx_beat_t);

    logic [EW-1:0]        elem_q, elem_d;
    logic [LW-1:0]        line_q, line_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 frame_done_q, frame_done_d;

    rx_beat_t        push_beat, head;
    logic [BW-1:0]   fifo_dout;
    logic            fifo_full, fifo_empty;
    logic            in_fire, drop, out_fire, last_elem, last_line;

    assign last_elem = (elem_q == EW'(ROW - 1));
    assign last_line = (line_q == LW'(CLO - 1));
    assign in_fire   = s_axis_tvalid && !fifo_full;
    assign drop      = s_axis_tvalid && fifo_full;
    assign out_fire  = m_axis_tvalid && m_axis_tready;

    assign push_beat.data    = s_axis_tdata;
    assign push_beat.tag.sof = (elem_q == '0) && (line_q == '0);
    assign push_beat.tag.eol = last_elem;
    assign push_beat.tag.eof = last_elem && last_line;

    axis_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_fire),
        .din_i   (push_beat),
        .pop_i   (m_axis_tready),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head = rx_beat_t'(fifo_dout);

    // Head fields are masked while empty so the unreset storage never leaks out.
    assign s_axis_tready = !fifo_full;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : head.data;
    assign m_axis_tlast  = !fifo_empty && head.tag.eof;
    assign m_axis_tuser  = fifo_empty ? 2'b00 : {head.tag.eol, head.tag.sof};
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign ovf_err       = ovf_q;

    always_comb begin
        elem_d       = elem_q;
        line_d       = line_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        ovf_d        = ovf_q;
        frame_done_d = out_fire && head.tag.eof;

        // Indices advance on dropped beats too, keeping frame alignment.
        if (s_axis_tvalid) begin
            if (last_elem) begin
                elem_d = '0;
                line_d = last_line ? '0 : line_q + 1'b1;
            end else begin
                elem_d = elem_q + 1'b1;
            end
        end

        if (frame_done_d) frame_cnt_d = frame_cnt_q + 1'b1;

        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = err_clr ? CNT_WIDTH'(1) :
                         (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;
        end else if (err_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q       <= '0;
            line_q       <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            elem_q       <= elem_d;
            line_q       <= line_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_matrix_axis_rx.sv
// Directed bench for matrix_axis_rx: a 4x3 instance for framing, stalls,
// error-clear and reset; a 4x5 instance with 3-bit counters for overflow.
module tb_matrix_axis_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [31:0] a_sdata, a_mdata;
    logic        a_svalid, a_sready, a_mvalid, a_mready, a_mlast, a_done, a_ovf, a_clr;
    logic [1:0]  a_muser;
    logic [15:0] a_fcnt, a_dcnt;

    logic [31:0] b_sdata, b_mdata;
    logic        b_svalid, b_sready, b_mvalid, b_mready, b_mlast, b_done, b_ovf, b_clr;
    logic [1:0]  b_muser;
    logic [2:0]  b_fcnt, b_dcnt;

    matrix_axis_rx #(.DATA_WIDTH(32), .ROW(4), .CLO(3), .FIFO_DEPTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(a_sdata), .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
        .m_axis_tlast(a_mlast), .m_axis_tuser(a_muser), .frame_done(a_done),
        .frame_cnt(a_fcnt), .drop_cnt(a_dcnt), .ovf_err(a_ovf), .err_clr(a_clr)
    );

    matrix_axis_rx #(.DATA_WIDTH(32), .ROW(4), .CLO(5), .FIFO_DEPTH(16), .CNT_WIDTH(3)) dut_bp (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
        .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser), .frame_done(b_done),
        .frame_cnt(b_fcnt), .drop_cnt(b_dcnt), .ovf_err(b_ovf), .err_clr(b_clr)
    );

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        last;
    } vec_t;

    vec_t tbl [12];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        a_sdata = '0; a_svalid = 0; a_mready = 0; a_clr = 0;
        b_sdata = '0; b_svalid = 0; b_mready = 0; b_clr = 0;
        rst_n = 0;
        repeat (2) tick;
        rst_n = 1;
        tick;
    endtask

    task automatic a_push(input logic [31:0] d);
        a_sdata = d; a_svalid = 1; tick; a_svalid = 0;
    endtask

    task automatic b_push(input logic [31:0] d);
        b_sdata = d; b_svalid = 1; tick; b_svalid = 0;
    endtask

    // Streams the 12-entry table through instance A with tready held high.
    task automatic run_table(input string tag);
        int k = 0;
        int nd = 0;
        a_mready = 1;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    a_sdata = tbl[i].data; a_svalid = 1; tick;
                end
                a_svalid = 0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (a_done) nd++;
                    if (a_mvalid && a_mready && k < 12) begin
                        check($sformatf("%s_data%0d", tag, k), a_mdata, tbl[k].data);
                        check($sformatf("%s_sof%0d", tag, k), a_muser[0], tbl[k].sof);
                        check($sformatf("%s_eol%0d", tag, k), a_muser[1], tbl[k].eol);
                        check($sformatf("%s_last%0d", tag, k), a_mlast, tbl[k].last);
                        k++;
                    end
                end
            end
        join
        check({tag, "_beats"}, k, 12);
        check({tag, "_done_pulses"}, nd, 1);
        check({tag, "_frame_cnt"}, a_fcnt, 1);
        check({tag, "_drop_cnt"}, a_dcnt, 0);
        a_mready = 0;
    endtask

    task automatic stall_test;
        logic [31:0] pd = '0;
        logic [1:0]  pu = '0;
        logic        pl = 0;
        logic        pstall = 0;
        int n = 0, nlast = 0, ndone = 0;
        do_reset;
        fork
            begin
                for (int i = 0; i < 36; i++) begin
                    a_push(32'(i + 1));
                    tick;
                end
            end
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (a_done) ndone++;
                    if (pstall) begin
                        check("hold_valid", a_mvalid, 1);
                        check("hold_data", a_mdata, pd);
                        check("hold_user", a_muser, pu);
                        check("hold_last", a_mlast, pl);
                    end
                    a_mready = ($urandom_range(0, 9) >= 3);
                    if (a_mvalid && a_mready) begin
                        check("stall_data", a_mdata, n + 1);
                        check("stall_user", a_muser, {(n % 4 == 3), (n % 12 == 0)});
                        check("stall_last", a_mlast, (n % 12 == 11));
                        if (a_mlast) nlast++;
                        n++;
                    end
                    pstall = a_mvalid && !a_mready;
                    pd = a_mdata; pu = a_muser; pl = a_mlast;
                end
            end
        join
        a_mready = 0;
        check("stall_beats", n, 36);
        check("stall_tlast_cnt", nlast, 3);
        check("stall_done_cnt", ndone, 3);
        check("stall_frame_cnt", a_fcnt, 3);
        check("stall_drop_cnt", a_dcnt, 0);
    endtask

    task automatic err_test;
        do_reset;
        for (int i = 0; i < 15; i++) a_push(32'(i + 1));
        check("err_ready_15", a_sready, 1);
        a_push(32'd16);
        check("err_ready_full", a_sready, 0);
        a_push(32'd17);
        a_push(32'd18);
        check("err_drop2", a_dcnt, 2);
        check("err_ovf_set", a_ovf, 1);
        a_sdata = 32'd19; a_svalid = 1; a_clr = 1; tick;
        check("clr_with_drop_cnt", a_dcnt, 1);
        check("clr_with_drop_ovf", a_ovf, 1);
        a_svalid = 0; tick;
        check("clr_alone_cnt", a_dcnt, 0);
        check("clr_alone_ovf", a_ovf, 0);
        a_clr = 0;
        a_sdata = 32'd20; a_svalid = 1; a_mready = 1; tick;
        a_svalid = 0; a_mready = 0;
        check("full_pop_drop", a_dcnt, 1);
        check("full_pop_ready", a_sready, 1);
        check("full_pop_head", a_mdata, 2);
        check("full_pop_valid", a_mvalid, 1);
    endtask

    task automatic midreset_test;
        do_reset;
        for (int i = 0; i < 5; i++) a_push(32'(i + 1));
        a_mready = 1; tick; tick; a_mready = 0;
        check("mid_valid", a_mvalid, 1);
        check("mid_head", a_mdata, 3);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("async_valid", a_mvalid, 0);
        check("async_data", a_mdata, 0);
        check("async_user", a_muser, 0);
        check("async_last", a_mlast, 0);
        tick;
        rst_n = 1;
        tick;
        run_table("rst");
    endtask

    task automatic bp_test;
        int k = 0, nl = 0, nd = 0, lastpos = -1;
        do_reset;
        for (int i = 0; i < 15; i++) b_push(32'(i + 1));
        check("bp_ready_15", b_sready, 1);
        b_push(32'd16);
        check("bp_ready_16", b_sready, 0);
        for (int i = 16; i < 20; i++) b_push(32'(i + 1));
        check("bp_drop_cnt", b_dcnt, 4);
        check("bp_ovf", b_ovf, 1);
        b_mready = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b_done) nd++;
            if (b_mvalid && b_mready) begin
                check("bp_drain_data", b_mdata, k + 1);
                check("bp_drain_sof", b_muser[0], (k == 0));
                if (b_mlast) nl++;
                k++;
            end
        end
        check("bp_drain_beats", k, 16);
        check("bp_drain_tlast", nl, 0);
        check("bp_drain_done", nd, 0);
        check("bp_drain_fcnt", b_fcnt, 0);
        check("bp_empty", b_mvalid, 0);
        tick;
        k = 0; nl = 0; nd = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    b_sdata = 32'(101 + i); b_svalid = 1; tick;
                end
                b_svalid = 0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (b_done) nd++;
                    if (b_mvalid && b_mready) begin
                        check("bp_f2_data", b_mdata, 101 + k);
                        check("bp_f2_sof", b_muser[0], (k == 0));
                        check("bp_f2_eol", b_muser[1], (k % 4 == 3));
                        if (b_mlast) begin nl++; lastpos = k; end
                        k++;
                    end
                end
            end
        join
        check("bp_f2_beats", k, 20);
        check("bp_f2_tlast_cnt", nl, 1);
        check("bp_f2_tlast_pos", lastpos, 19);
        check("bp_f2_done", nd, 1);
        check("bp_f2_fcnt", b_fcnt, 1);
        b_mready = 0;
        for (int i = 0; i < 21; i++) b_push(32'(200 + i));
        check("bp_drop_sat", b_dcnt, 7);
        check("bp_ovf_sat", b_ovf, 1);
    endtask

    initial begin
        tbl[0]  = '{32'd1,  1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'd2,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{32'd3,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{32'd4,  1'b0, 1'b1, 1'b0};
        tbl[4]  = '{32'd5,  1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'd6,  1'b0, 1'b0, 1'b0};
        tbl[6]  = '{32'd7,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{32'd8,  1'b0, 1'b1, 1'b0};
        tbl[8]  = '{32'd9,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'd10, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'd11, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{32'd12, 1'b0, 1'b1, 1'b1};

        do_reset;
        check("rst_mvalid", a_mvalid, 0);
        check("rst_mdata", a_mdata, 0);
        check("rst_muser", a_muser, 0);
        check("rst_mlast", a_mlast, 0);
        check("rst_done", a_done, 0);
        check("rst_fcnt", a_fcnt, 0);
        check("rst_dcnt", a_dcnt, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_sready", a_sready, 1);

        run_table("frm");
        stall_test;
        err_test;
        midreset_test;
        bp_test;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
